scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL, default 4, the number of clock cycles each select index is held; the legal range is 1..256.
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
REQ-006 Port: stop  input  1  abort request; sampled only in SCAN.
REQ-007 Port: cont  input  1  continuous mode; latched at start (1 = repeat the range forever).
REQ-008 Port: first  input  [0:3]  first index of the range; bit 0 is the MSB; latched at start.
REQ-009 Port: last  input  [0:3]  last index of the range; bit 0 is the MSB; latched at start.
REQ-010 Port: sel  output  [0:3]  current select, feeding the 4-to-16 decoder `in` input; bit 0 is the MSB.
REQ-011 Port: sel_en  output  1  decoder enable; high only while an index is being driven.
REQ-012 Port: busy  output  1  high while in SCAN.
REQ-013 Port: done  output  1  one-cycle pulse when a non-continuous scan completes.
REQ-014 Port: wrap  output  1  one-cycle pulse when a continuous scan restarts at `first`.

Function
REQ-015 The state machine SHALL have three states: IDLE, SCAN, DONE. All outputs SHALL be registered.
REQ-016 IDLE SHALL drive sel_en=0, busy=0, done=0 and wrap=0, and SHALL hold sel at its last value.
REQ-017 In IDLE with start=1 at edge N, the block SHALL latch first, last and cont, and from cycle N+1 SHALL drive sel=first, sel_en=1, busy=1, with state SCAN and the dwell count cleared to 0.
REQ-018 In SCAN the dwell count SHALL increment each cycle, so that each index is held for exactly DWELL cycles.
REQ-019 When the dwell count reaches DWELL-1 and sel≠last, on the next cycle sel SHALL become (sel+1) mod 16 and the dwell count SHALL clear. Stepping from 15 to 0 is legal, so a range with first>last wraps through 15.
REQ-020 When the dwell count reaches DWELL-1, sel=last and cont=1, on the next cycle sel SHALL become first, wrap SHALL be 1 for that one cycle, and sel_en SHALL stay 1 with no gap.
REQ-021 When the dwell count reaches DWELL-1, sel=last and cont=0, the next state SHALL be DONE.
REQ-022 DONE SHALL last one cycle with done=1, sel_en=0 and busy=0, and SHALL then go to IDLE.
REQ-023 first=last SHALL produce one index held for DWELL cycles; the first to last range covers all 16 indices at most.
REQ-024 stop=1 in SCAN SHALL force IDLE on the next cycle with sel_en=0; done SHALL not pulse.
REQ-025 If stop coincides with the final dwell cycle, stop SHALL win: no done and no wrap.
REQ-026 start while in SCAN or DONE SHALL be ignored. stop while in IDLE SHALL be ignored. If start and stop are both 1 in IDLE, start SHALL be accepted.
REQ-027 Changes on first, last or cont during SCAN SHALL have no effect until the next accepted start.
REQ-028 sel_en and sel SHALL change on the same clock edge, so the decoder never sees a stale index while enabled.

Reset
REQ-029 rst=1 SHALL force state IDLE, sel=0, sel_en=0, busy=0, done=0, wrap=0, clear the dwell count, and clear the latched first/last/cont to 0.
REQ-030 rst SHALL take priority over start and stop. Reset asserted mid-scan SHALL drop sel_en on the next edge with no done pulse.

Structure
REQ-031 A shared package scan_pkg SHALL hold the state encoding (IDLE, SCAN, DONE), SEL_W=4 and NUM_OUT=16.
REQ-032 The dwell counter SHALL be a single sub-module, dwell_timer, parameterised by DWELL. Its inputs SHALL be clear and run, and its output SHALL be a terminal-count pulse.
REQ-033 The block SHALL contain no decoder logic; it drives the existing 4-to-16 decoder externally.

Verification
REQ-034 Single scan: DWELL=4, first=0, last=3, cont=0, start at cycle N -> sel steps 0,1,2,3 over cycles N+1..N+16 with sel_en=1, then done=1 at N+17, then IDLE.
REQ-035 Wrapped range: first=14, last=1, DWELL=1 -> sel sequence 14,15,0,1, then one done pulse.
REQ-036 Continuous mode: first=5, last=6, cont=1, DWELL=2 -> sel sequence 5,5,6,6,5,... with a wrap pulse on each return to 5, no done, and sel_en never low.
REQ-037 Abort: stop on the final dwell cycle of last -> sel_en=0 on the next cycle, with done=0 and wrap=0.
REQ-038 Mid-scan reset: rst during SCAN -> all outputs 0 and sel=0 on the next cycle; a start applied afterwards works normally.
REQ-039 Ignored inputs: start during SCAN and first=last=9 -> the re-start is ignored, and index 9 is held for exactly DWELL cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: state encoding, select width, decoder fan-out.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_pkg;

    localparam int NUM_OUT = 16;
    localparam int SEL_W   = $clog2(NUM_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Natural overflow gives the 15 -> 0 step for ranges that wrap.
    function automatic logic [0:SEL_W-1] next_index(input logic [0:SEL_W-1] cur);
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Dwell counter: counts cycles while run is high and pulses tc on the last cycle of each dwell.
// Latency: tc is combinational from the count; the count restarts at 0 the cycle after tc.
// Backpressure: none; clear has priority over run.
module dwell_timer
    import scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc    = run && (cnt_q == LAST_CNT);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 4-bit select from first to last, DWELL cycles per index, for an external 4-to-16 decoder.
// Latency: sel/sel_en valid the cycle after start is sampled; done/wrap are one-cycle registered pulses.
// Backpressure: none; start is ignored outside IDLE, stop aborts SCAN on the next edge.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [0:SEL_W-1] first,
    input  logic [0:SEL_W-1] last,
    output logic [0:SEL_W-1] sel,
    output logic             sel_en,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           state_q;
    state_e           state_d;
    logic [0:SEL_W-1] sel_q;
    logic [0:SEL_W-1] sel_d;
    logic             sel_en_q;
    logic             sel_en_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [0:SEL_W-1] first_q;
    logic [0:SEL_W-1] first_d;
    logic [0:SEL_W-1] last_q;
    logic [0:SEL_W-1] last_d;
    logic             cont_q;
    logic             cont_d;

    logic             timer_clear;
    logic             timer_run;
    logic             dwell_tc;

    // The counter only runs in SCAN, so it is already zero on the first cycle of every scan.
    assign timer_run   = (state_q == SCAN);
    assign timer_clear = (state_q != SCAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .tc    (dwell_tc)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        first_d  = first_q;
        last_d   = last_q;
        cont_d   = cont_q;

        case (state_q)
            IDLE: begin
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    first_d  = first;
                    last_d   = last;
                    cont_d   = cont;
                    sel_d    = first;
                    sel_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                // Abort outranks every end-of-dwell action, including done and wrap.
                if (stop) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (dwell_tc) begin
                    if (sel_q != last_q) begin
                        sel_d = next_index(sel_q);
                    end else if (cont_q) begin
                        sel_d  = first_q;
                        wrap_d = 1'b1;
                    end else begin
                        state_d  = DONE;
                        sel_en_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            first_q  <= first_d;
            last_q   <= last_d;
            cont_q   <= cont_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = sel_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: three sequencers (DWELL 4, 1, 2) share one stimulus stream; each has its own expected queue.
module tb_scan_sequencer;

    localparam int ND  = 3;
    localparam int DW0 = 4;
    localparam int DW1 = 1;
    localparam int DW2 = 2;

    typedef struct packed {
        logic [3:0] sel;
        logic       sel_en;
        logic       busy;
        logic       wrap;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [0:3] first;
    logic [0:3] last;

    logic [0:3] sel_o    [ND];
    logic       sel_en_o [ND];
    logic       busy_o   [ND];
    logic       done_o   [ND];
    logic       wrap_o   [ND];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [3:0] idle_sel [ND];
    logic       mon_en;
    int         errors;
    int         checks;

    scan_sequencer #(.DWELL(DW0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .first(first), .last(last), .sel(sel_o[0]), .sel_en(sel_en_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .wrap(wrap_o[0])
    );

    scan_sequencer #(.DWELL(DW1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .first(first), .last(last), .sel(sel_o[1]), .sel_en(sel_en_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .wrap(wrap_o[1])
    );

    scan_sequencer #(.DWELL(DW2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .first(first), .last(last), .sel(sel_o[2]), .sel_en(sel_en_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .wrap(wrap_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw_of(input int d);
        case (d)
            0:       return DW0;
            1:       return DW1;
            default: return DW2;
        endcase
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Reference: cycle t of a scan shows index first + (t mod (len*dw)) / dw; each later pass opens with wrap.
    function automatic exp_t stream_at(input int t, input int f, input int len, input int dw);
        exp_t e;
        int   per;
        int   pos;
        per      = len * dw;
        pos      = (t % per) / dw;
        e.sel    = 4'((f + pos) % 16);
        e.sel_en = 1'b1;
        e.busy   = 1'b1;
        e.wrap   = (t >= per) && ((t % per) == 0);
        e.done   = 1'b0;
        return e;
    endfunction

    // Monitor: every presented output pops one expectation; quiet cycles must be idle with sel held.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                exp_t act;
                exp_t e;
                act.sel    = sel_o[d];
                act.sel_en = sel_en_o[d];
                act.busy   = busy_o[d];
                act.wrap   = wrap_o[d];
                act.done   = done_o[d];
                checks++;
                if (act.sel_en || act.done || act.wrap) begin
                    if (qsize(d) == 0) begin
                        errors++;
                        $display("FAIL unexpected_out dut%0d t=%0t: got sel=%0d en=%0b busy=%0b wrap=%0b done=%0b, expected no output",
                                 d, $time, act.sel, act.sel_en, act.busy, act.wrap, act.done);
                    end else begin
                        e = pop_exp(d);
                        if (act !== e) begin
                            errors++;
                            $display("FAIL seq dut%0d t=%0t: got sel=%0d en=%0b busy=%0b wrap=%0b done=%0b, expected sel=%0d en=%0b busy=%0b wrap=%0b done=%0b",
                                     d, $time, act.sel, act.sel_en, act.busy, act.wrap, act.done,
                                     e.sel, e.sel_en, e.busy, e.wrap, e.done);
                        end
                    end
                end else if (act.busy !== 1'b0 || act.sel !== idle_sel[d]) begin
                    errors++;
                    $display("FAIL idle dut%0d t=%0t: got busy=%0b sel=%0d, expected busy=0 sel=%0d",
                             d, $time, act.busy, act.sel, idle_sel[d]);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({sel_o[d], sel_en_o[d], busy_o[d], done_o[d], wrap_o[d]} !== 8'h00) begin
                errors++;
                $display("FAIL %s dut%0d: got sel=%0d en=%0b busy=%0b done=%0b wrap=%0b, expected all zero",
                         tag, d, sel_o[d], sel_en_o[d], busy_o[d], done_o[d], wrap_o[d]);
            end
        end
    endtask

    // mode 0: run to completion, 1: stop during active cycle k, 2: reset during active cycle k.
    // k_req <= 0 picks a random k.
    task automatic run_scan(input int f, input int l, input bit c, input int mode_in, input int k_req);
        int   mode;
        int   len;
        int   k;
        int   min_l;
        int   max_l;
        int   n;
        int   l_d   [ND];
        int   idle_v[ND];
        exp_t e;

        mode  = (c && mode_in == 0) ? 1 : mode_in;
        len   = ((l - f + 16) % 16) + 1;
        min_l = 1_000_000;
        max_l = 0;
        for (int d = 0; d < ND; d++) begin
            l_d[d] = c ? 1_000_000 : len * dw_of(d);
            if (l_d[d] < min_l) min_l = l_d[d];
            if (l_d[d] > max_l) max_l = l_d[d];
        end
        if (mode == 0)       k = max_l;
        else if (k_req > 0)  k = k_req;
        else                 k = 1 + $urandom_range(0, c ? 3 * len * DW0 : len * DW0 + 1);

        for (int d = 0; d < ND; d++) begin
            n = (k < l_d[d]) ? k : l_d[d];
            for (int t = 0; t < n; t++) push_exp(d, stream_at(t, f, len, dw_of(d)));
            if (!c && (mode == 0 || k > l_d[d])) begin
                e.sel = 4'(l); e.sel_en = 1'b0; e.busy = 1'b0; e.wrap = 1'b0; e.done = 1'b1;
                push_exp(d, e);
            end
            if (mode != 0 && k <= l_d[d]) idle_v[d] = int'(stream_at(k - 1, f, len, dw_of(d)).sel);
            else                          idle_v[d] = l;
        end

        @(posedge clk); #1;
        start = 1'b1;
        first = 4'(f);
        last  = 4'(l);
        cont  = c;
        stop  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            idle_sel[d] = 4'(idle_v[d]);
            checks++;
            if (sel_en_o[d] !== 1'b1 || busy_o[d] !== 1'b1 || sel_o[d] !== 4'(f)) begin
                errors++;
                $display("FAIL start_latency dut%0d: got en=%0b busy=%0b sel=%0d, expected en=1 busy=1 sel=%0d",
                         d, sel_en_o[d], busy_o[d], sel_o[d], f);
            end
        end

        for (int j = 1; j <= k; j++) begin
            start = (j <= min_l) ? 1'($urandom_range(0, 1)) : 1'b0;
            first = 4'($urandom_range(0, 15));
            last  = 4'($urandom_range(0, 15));
            cont  = 1'($urandom_range(0, 1));
            stop  = (mode == 1 && j == k);
            rst   = (mode == 2 && j == k);
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        if (mode == 2) begin
            for (int d = 0; d < ND; d++) idle_sel[d] = 4'd0;
            check_zero("midscan_reset");
        end

        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (qsize(d) != 0) begin
                errors++;
                $display("FAIL drain dut%0d f=%0d l=%0d c=%0b mode=%0d k=%0d: got %0d outputs still pending, expected 0",
                         d, f, l, c, mode, k, qsize(d));
                case (d)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        int l;
        bit c;
        int mode;

        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        cont   = 1'b0;
        first  = 4'd0;
        last   = 4'd0;
        for (int d = 0; d < ND; d++) idle_sel[d] = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_scan(0, 3, 1'b0, 0, 0);     // single scan, done at N+17 for DWELL=4
        run_scan(14, 1, 1'b0, 0, 0);    // range wrapping through 15
        run_scan(5, 6, 1'b1, 1, 13);    // continuous with wrap pulses
        run_scan(5, 6, 1'b1, 1, 4);     // stop on final dwell of last in continuous mode (DWELL=2)
        run_scan(0, 3, 1'b0, 1, 16);    // stop on final dwell of last (DWELL=4)
        run_scan(2, 7, 1'b0, 2, 5);     // reset mid-scan
        run_scan(2, 7, 1'b0, 0, 0);     // normal scan after reset
        run_scan(9, 9, 1'b0, 0, 0);     // single index with ignored re-starts
        run_scan(0, 15, 1'b0, 0, 0);    // full range
        run_scan(15, 14, 1'b0, 0, 0);   // full range starting at 15

        for (int r = 0; r < 40; r++) begin
            f    = $urandom_range(0, 15);
            l    = $urandom_range(0, 15);
            c    = ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 2);
            run_scan(f, l, c, mode, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
